// File: rtl/dbg_slave_sampler.sv
// Virtual-JTAG debug-slave front end oversampled in the system clock domain.
// Optional DBG_SLAVE_PARITY_EN: even parity in sr[DR_W-2] gates the update strobes.

module dbg_slave_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] chain;

   always_ff @(posedge clk) begin
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];
endmodule

module dbg_slave_sampler #(
   parameter int DR_W        = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2,
   localparam int NCH        = 2**IR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tck_i,
   input  logic                tdi_i,
   input  logic                vs_cdr_i,
   input  logic                vs_sdr_i,
   input  logic                vs_udr_i,
   input  logic                vs_uir_i,
   input  logic [IR_W-1:0]     ir_in_i,
   input  logic [NCH*DR_W-1:0] capture_data_i,
   input  logic [IR_W-1:0]     status_i,
   output logic                tdo_o,
   output logic [IR_W-1:0]     ir_out_o,
   output logic [DR_W-1:0]     jdo_o,
   output logic [IR_W-1:0]     ir_o,
   output logic [NCH-1:0]      take_action_o,
   output logic [NCH-1:0]      take_no_action_o,
   output logic [7:0]          upd_cnt_o,
   output logic                parity_err_o
);
   localparam int NSIG = 6;
   localparam int S_TCK = 0, S_TDI = 1, S_CDR = 2, S_SDR = 3, S_UDR = 4, S_UIR = 5;
   localparam int WARM = SYNC_STAGES + 1;
   localparam int WW   = $clog2(WARM + 1);

   logic [NSIG-1:0]           raw, syn;
   logic [IR_W-1:0]           ir_in_s;
   logic [WW-1:0]             warm_cnt;
   logic                      edge_en;
   logic                      tck_h, udr_h, uir_h;
   logic                      tck_rise, tck_fall, udr_rise, uir_rise;
   logic [DR_W-1:0]           sr;
   logic [NCH-1:0][DR_W-1:0]  cap_arr;
   logic [NCH-1:0]            ir_sel;
   logic [NCH-1:0]            pend_act, pend_noact;
   logic                      par_ok;

   assign raw = {vs_uir_i, vs_udr_i, vs_sdr_i, vs_cdr_i, tdi_i, tck_i};

   genvar g;
   generate
      for (g = 0; g < NSIG; g++) begin : g_sync
         dbg_slave_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw[g]),
            .q     (syn[g])
         );
      end
   endgenerate

   dbg_slave_sync #(.W(IR_W), .STAGES(SYNC_STAGES)) u_sync_ir (
      .clk   (clk),
      .reset (reset),
      .d     (ir_in_i),
      .q     (ir_in_s)
   );

   // Synchroniser chains restart from 0 after reset; masking edges until the
   // chains and history have refilled hides levels that were already high.
   assign edge_en  = (warm_cnt == WW'(WARM));
   assign tck_rise = edge_en &  syn[S_TCK] & ~tck_h;
   assign tck_fall = edge_en & ~syn[S_TCK] &  tck_h;
   assign udr_rise = edge_en &  syn[S_UDR] & ~udr_h;
   assign uir_rise = edge_en &  syn[S_UIR] & ~uir_h;

   assign cap_arr = capture_data_i;
   assign ir_sel  = NCH'(1) << ir_o;

`ifdef DBG_SLAVE_PARITY_EN
   assign par_ok = (sr[DR_W-2] == ^{sr[DR_W-1], sr[DR_W-3:0]});

   always_ff @(posedge clk) begin
      if (reset)                   parity_err_o <= 1'b0;
      else if (udr_rise && !par_ok) parity_err_o <= 1'b1;
   end
`else
   assign par_ok       = 1'b1;
   assign parity_err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         warm_cnt         <= '0;
         tck_h            <= 1'b0;
         udr_h            <= 1'b0;
         uir_h            <= 1'b0;
         sr               <= '0;
         tdo_o            <= 1'b0;
         ir_o             <= '0;
         jdo_o            <= '0;
         upd_cnt_o        <= '0;
         ir_out_o         <= '0;
         pend_act         <= '0;
         pend_noact       <= '0;
         take_action_o    <= '0;
         take_no_action_o <= '0;
      end else begin
         if (!edge_en) warm_cnt <= warm_cnt + WW'(1);
         tck_h    <= syn[S_TCK];
         udr_h    <= syn[S_UDR];
         uir_h    <= syn[S_UIR];
         ir_out_o <= status_i;

         if (tck_rise) begin
            if (syn[S_CDR])      sr <= cap_arr[ir_o];
            else if (syn[S_SDR]) sr <= {syn[S_TDI], sr[DR_W-1:1]};
         end
         if (tck_fall) tdo_o <= sr[0];

         // ir_o still holds the old instruction here, so a coincident IR
         // update does not redirect the strobe.
         if (uir_rise) ir_o <= ir_in_s;

         pend_act   <= '0;
         pend_noact <= '0;
         if (udr_rise) begin
            jdo_o     <= sr;
            upd_cnt_o <= upd_cnt_o + 8'd1;
            if (par_ok) begin
               if (sr[DR_W-1]) pend_act   <= ir_sel;
               else            pend_noact <= ir_sel;
            end
         end
         take_action_o    <= pend_act;
         take_no_action_o <= pend_noact;
      end
   end
endmodule

// File: tb/tb_dbg_slave_sampler.sv
// Scoreboard bench for dbg_slave_sampler: JTAG scans driven at clk/8, updates checked on output.
module tb_dbg_slave_sampler;
   localparam int DR_W = 38, IR_W = 2, NCH = 4, SS = 2;

   logic                     clk = 1'b0, reset = 1'b1;
   logic                     tck_i = 1'b0, tdi_i = 1'b0;
   logic                     vs_cdr_i = 1'b0, vs_sdr_i = 1'b0, vs_udr_i = 1'b0, vs_uir_i = 1'b0;
   logic [IR_W-1:0]          ir_in_i = '0, status_i = 2'd2;
   logic [NCH-1:0][DR_W-1:0] cap = '0;
   logic                     tdo_o, parity_err_o;
   logic [IR_W-1:0]          ir_out_o, ir_o;
   logic [DR_W-1:0]          jdo_o;
   logic [NCH-1:0]           take_action_o, take_no_action_o;
   logic [7:0]               upd_cnt_o;

   dbg_slave_sampler #(.DR_W(DR_W), .IR_W(IR_W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .tck_i(tck_i), .tdi_i(tdi_i),
      .vs_cdr_i(vs_cdr_i), .vs_sdr_i(vs_sdr_i), .vs_udr_i(vs_udr_i), .vs_uir_i(vs_uir_i),
      .ir_in_i(ir_in_i), .capture_data_i(cap), .status_i(status_i),
      .tdo_o(tdo_o), .ir_out_o(ir_out_o), .jdo_o(jdo_o), .ir_o(ir_o),
      .take_action_o(take_action_o), .take_no_action_o(take_no_action_o),
      .upd_cnt_o(upd_cnt_o), .parity_err_o(parity_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DR_W-1:0] jdo;
      logic [NCH-1:0]  act;
      logic [NCH-1:0]  noact;
      logic [7:0]      cnt;
      int              t0;
   } exp_t;

   exp_t            q[$];
   exp_t            cur;
   int              n_chk = 0, n_err = 0, cyc = 0;
   logic [DR_W-1:0] m_sr = '0;
   logic [IR_W-1:0] m_ir = '0;
   logic [7:0]      m_cnt = '0, prev_cnt = '0;
   logic            m_perr = 1'b0;
   bit              strobe_due = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [DR_W-1:0] fix_par(input logic [DR_W-1:0] v);
      logic [DR_W-1:0] r;
      r = v;
`ifdef DBG_SLAVE_PARITY_EN
      r[DR_W-2] = ^{v[DR_W-1], v[DR_W-3:0]};
`endif
      return r;
   endfunction

   function automatic bit par_good(input logic [DR_W-1:0] v);
`ifdef DBG_SLAVE_PARITY_EN
      return v[DR_W-2] == ^{v[DR_W-1], v[DR_W-3:0]};
`else
      return 1'b1;
`endif
   endfunction

   task automatic tck_pulse();
      tck_i = 1'b1; step(4);
      tck_i = 1'b0; step(4);
   endtask

   task automatic ir_scan(input logic [IR_W-1:0] v);
      ir_in_i = v; step(1);
      vs_uir_i = 1'b1; step(4);
      vs_uir_i = 1'b0; step(4);
      m_ir = v;
   endtask

   // Capture then shift val in LSB first; TDO must replay the captured word.
   task automatic dr_scan(input logic [DR_W-1:0] val);
      logic [DR_W-1:0] got;
      got = '0;
      vs_cdr_i = 1'b1; step(2);
      tck_pulse();
      got[0] = tdo_o;
      vs_cdr_i = 1'b0; vs_sdr_i = 1'b1; step(2);
      for (int i = 0; i < DR_W; i++) begin
         tdi_i = val[i]; step(1);
         tck_pulse();
         if (i < DR_W-1) got[i+1] = tdo_o;
      end
      vs_sdr_i = 1'b0; step(2);
      check("tdo_capture", got, cap[m_ir]);
      m_sr = val;
   endtask

   task automatic do_update(input bit with_uir);
      exp_t e;
      bit   good;
      good    = par_good(m_sr);
      m_cnt   = m_cnt + 8'd1;
      e.jdo   = m_sr;
      e.cnt   = m_cnt;
      e.act   = '0;
      e.noact = '0;
      if (good) begin
         if (m_sr[DR_W-1]) e.act[m_ir]   = 1'b1;
         else              e.noact[m_ir] = 1'b1;
      end else m_perr = 1'b1;
      vs_udr_i = 1'b1;
      if (with_uir) vs_uir_i = 1'b1;
      e.t0 = cyc;
      q.push_back(e);
      step(4);
      vs_udr_i = 1'b0; vs_uir_i = 1'b0;
      step(4);
      if (with_uir) m_ir = ir_in_i;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_cnt   = upd_cnt_o;
         strobe_due = 0;
      end else begin
         if (strobe_due) begin
            check("take_action", take_action_o, cur.act);
            check("take_no_action", take_no_action_o, cur.noact);
            check("strobe_latency", cyc - cur.t0, SS + 2);
            strobe_due = 0;
         end else if ((take_action_o | take_no_action_o) != '0)
            check("spurious_strobe", {take_action_o, take_no_action_o}, 0);
         if (upd_cnt_o != prev_cnt) begin
            if (q.size() == 0) check("unexpected_update", upd_cnt_o, prev_cnt);
            else begin
               cur = q.pop_front();
               check("jdo", jdo_o, cur.jdo);
               check("upd_cnt", upd_cnt_o, cur.cnt);
               strobe_due = 1;
            end
            prev_cnt = upd_cnt_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r;
      logic [1:0]  ch;

      // Reset with tck and udr already high: warm-up must swallow both.
      tck_i = 1'b1; vs_udr_i = 1'b1;
      step(5);
      reset = 1'b0;
      step(10);
      check("rst_jdo", jdo_o, 0);
      check("rst_cnt", upd_cnt_o, 0);
      check("rst_ir", ir_o, 0);
      check("rst_tdo", tdo_o, 0);
      check("rst_perr", parity_err_o, 0);
      check("ir_out", ir_out_o, 2);
      tck_i = 1'b0; vs_udr_i = 1'b0;
      step(8);
      check("tdo_after_fall", tdo_o, 0);
      do_update(0);

      cap[2] = 38'h15_5555_5555;
      cap[1] = 38'h2A_AAAA_AAAA;
      ir_scan(2);
      check("ir_latch2", ir_o, 2);
      dr_scan(fix_par(38'h20_0000_00A5));
      do_update(0);
      check("jdo_hold", jdo_o, fix_par(38'h20_0000_00A5));

      ir_scan(1);
      dr_scan(fix_par(38'h0F_1234_5678));
      do_update(0);

      // IR update coincident with DR update: strobe stays on the old channel.
      dr_scan(fix_par(38'h3C_0000_1111));
      ir_in_i = 2'd3; step(1);
      do_update(1);
      check("ir_coincident", ir_o, 3);

      for (int k = 0; k < 4; k++) begin
         ch = 2'($urandom_range(0, 3));
         r = {$urandom(), $urandom()};
         cap[ch] = r[DR_W-1:0];
         ir_scan(ch);
         r = {$urandom(), $urandom()};
         dr_scan(fix_par(r[DR_W-1:0]));
         do_update(0);
      end

      status_i = 2'd1; step(2);
      check("ir_out_follow", ir_out_o, 1);

      while (m_cnt != 8'd0) do_update(0);
      step(2);
      check("cnt_wrap", upd_cnt_o, 0);

`ifdef DBG_SLAVE_PARITY_EN
      r = {$urandom(), $urandom()};
      dr_scan(fix_par(r[DR_W-1:0]) ^ (38'd1 << (DR_W-2)));
      do_update(0);
      step(2);
      check("perr_set", parity_err_o, 1);
      dr_scan(fix_par(38'h25_0F0F_0F0F));
      do_update(0);
      step(2);
      check("perr_sticky", parity_err_o, 1);
`else
      check("perr_tied", parity_err_o, 0);
`endif

      // Reset while a udr edge is still in the synchroniser.
      dr_scan(fix_par(38'h3F_FFFF_0000));
      vs_udr_i = 1'b1; step(1);
      reset = 1'b1; step(3);
      reset = 1'b0;
      m_sr = '0; m_ir = '0; m_cnt = '0; m_perr = 1'b0;
      step(6);
      vs_udr_i = 1'b0; step(8);
      check("midrst_cnt", upd_cnt_o, 0);
      check("midrst_jdo", jdo_o, 0);
      check("midrst_ir", ir_o, 0);
      check("midrst_perr", parity_err_o, m_perr);

      step(4);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dbg_slave_sampler.md
# dbg_slave_sampler

Parametrised successor of the Nios II debug-slave JTAG front end. Runs entirely in the system clock domain: it oversamples the virtual-JTAG signals (tck, tdi, capture/shift/update DR, update IR, IR value) and implements the TCK-side shift register internally. It decodes each completed DR update into per-instruction take_action / take_no_action strobes. It sits between the virtual-JTAG hub and the OCI debug logic (break, ocimem, trace control).

## Interface
Parameters:
- DR_W, 38, data-register width; bit DR_W-1 is the action bit.
- IR_W, 2, instruction width; NCH = 2**IR_W instruction channels.
- SYNC_STAGES, 2, synchroniser depth for every JTAG-side input (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active high.
- tck_i  in  1  raw JTAG TCK, sampled as data.
- tdi_i  in  1  raw TDI.
- vs_cdr_i / vs_sdr_i / vs_udr_i / vs_uir_i  in  1 each  virtual state levels.
- ir_in_i  in  IR_W  instruction value, stable while vs_uir_i is high.
- capture_data_i  in  NCH*DR_W  per-instruction capture word; channel k at [k*DR_W +: DR_W].
- status_i  in  IR_W  status returned on ir_out.
- tdo_o  out  1  serial data out.
- ir_out_o  out  IR_W  registered status_i.
- jdo_o  out  DR_W  last updated DR contents.
- ir_o  out  IR_W  instruction latched at the last IR update.
- take_action_o  out  NCH  one-cycle strobe per channel.
- take_no_action_o  out  NCH  one-cycle strobe per channel.
- upd_cnt_o  out  8  count of DR updates, wraps 255→0.
- parity_err_o  out  1  sticky parity error (macro only, else 0).

## Operation
- Every 1-bit input passes through its own SYNC_STAGES flop chain. ir_in_i is synchronised as a bus and is only sampled on a uir rising edge.
- Edge detection compares the synchronised value with a one-cycle history register. It yields tck_rise, tck_fall, udr_rise and uir_rise.
- Warm-up: a counter holds all edge detectors disabled for SYNC_STAGES+1 cycles after reset. This prevents false edges from inputs that are already high.
- On tck_rise:
  - If cdr is high, sr <= capture_data[ir].
  - Else if sdr is high, sr <= {tdi_s, sr[DR_W-1:1]} (LSB first out).
  - Otherwise sr holds.
- On tck_fall: tdo_o <= sr[0].
- On uir_rise: ir <= ir_in_s.
- On udr_rise:
  - jdo_o <= sr.
  - upd_cnt_o increments.
  - Exactly one strobe fires on the following cycle: take_action_o[ir] if sr[DR_W-1]=1, else take_no_action_o[ir].
  - All other strobe bits stay 0.
- Priority and simultaneity:
  - reset overrides everything.
  - cdr beats sdr.
  - udr_rise in the same cycle as tck_rise latches sr as it was before that cycle's shift.
  - uir_rise in the same cycle as udr_rise uses the old ir for the strobe.
- ir_out_o <= status_i every cycle.
- Reset values: sr, jdo_o, ir_o, tdo_o, ir_out_o, strobes, upd_cnt_o and parity_err_o are all 0; history registers are 0.
- A reset issued mid-scan discards the partial shift. No strobe fires for a udr that was pending when reset asserted.
- Sampling constraint: clk must be at least 4× tck_i so each tck level lasts ≥2 clk cycles. Slower clk is unsupported; no detection is performed.

## Timing
- Raw tck_i edge → sr or tdo_o update: SYNC_STAGES+1 clk edges.
- Raw vs_udr_i rise → jdo_o valid: SYNC_STAGES+1 edges.
- Strobe high: exactly one cycle, at edge SYNC_STAGES+2, coincident with jdo_o already stable.
- jdo_o and ir_o are held until the next udr_rise / uir_rise.
- Back-to-back updates are spaced by at least one full TCK period, so strobes never overlap.

## Configuration
- DBG_SLAVE_PARITY_EN defined:
  - sr[DR_W-2] is even parity over sr[DR_W-3:0] and sr[DR_W-1].
  - On udr_rise with a parity mismatch:
    - jdo_o still loads and upd_cnt_o still increments.
    - Neither strobe fires.
    - parity_err_o sets; only reset clears it.
- Macro undefined: no parity check, bit DR_W-2 is payload, parity_err_o is tied 0.

## Test plan
- Reset with tck_i=1 and vs_udr_i=1 held high → no strobe, sr=0, upd_cnt_o=0 after warm-up.
- IR=2; capture with capture_data ch2=38'h15_5555_5555; shift 38 bits of 38'h20_0000_00A5 → TDO bits equal 38'h15_5555_5555 LSB first; jdo_o=38'h20_0000_00A5; take_action_o=4'b0100 for one cycle at SYNC_STAGES+2 clk after the udr edge.
- IR=1, DR MSB=0 → take_no_action_o=4'b0010 pulse; take_action_o stays 0.
- uir_rise (IR 1→3) coincident with udr_rise → strobe on channel 1; ir_o=3 afterwards.
- 256 consecutive DR updates → upd_cnt_o wraps to 0.
- DBG_SLAVE_PARITY_EN with a corrupted parity bit → no strobe, parity_err_o=1 sticky. The next good update fires its strobe while parity_err_o remains 1.
